// File: rtl/rggen_register_master.sv
// rggen_register_master: host-side initiator that broadcasts one access to N register slaves and merges their replies.
// Optional wait timeout is compiled in with RGGEN_REGISTER_MASTER_TIMEOUT_EN.
module rggen_register_master #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_host_valid,
    output logic                            o_host_ready,
    input  logic [ADDRESS_WIDTH-1:0]        i_host_address,
    input  logic                            i_host_write,
    input  logic [DATA_WIDTH-1:0]           i_host_write_data,
    input  logic [DATA_WIDTH/8-1:0]         i_host_strobe,
    output logic                            o_host_response_valid,
    input  logic                            i_host_response_ready,
    output logic [DATA_WIDTH-1:0]           o_host_read_data,
    output logic [1:0]                      o_host_status,
    output logic                            o_register_request,
    output logic [ADDRESS_WIDTH-1:0]        o_register_address,
    output logic                            o_register_direction,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH/8-1:0]         o_register_write_strobe,
    output logic [DATA_WIDTH-1:0]           o_register_write_mask,
    input  logic [REGISTERS-1:0]            i_register_select,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
    input  logic [2*REGISTERS-1:0]          i_register_status
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_t;
    state_t                    r_state;
    state_t                    w_next;
    logic                      w_hit;
    logic                      w_done;
    logic                      w_timeout;
    logic [DATA_WIDTH-1:0]     w_read_data;
    logic [DATA_WIDTH-1:0]     w_mask;
    logic [1:0]                w_status;
    logic [ADDRESS_WIDTH-1:0]  r_address;
    logic                      r_write;
    logic [DATA_WIDTH-1:0]     r_write_data;
    logic [DATA_WIDTH/8-1:0]   r_strobe;
    logic [DATA_WIDTH-1:0]     r_mask;
    logic [DATA_WIDTH-1:0]     r_read_data;
    logic [1:0]                r_status;

    // Replies are OR-merged across every slave that is both selected and ready.
    always_comb begin
        w_hit       = |i_register_select;
        w_done      = |(i_register_select & i_register_ready);
        w_read_data = '0;
        w_status    = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_register_select[k] && i_register_ready[k]) begin
                w_read_data = w_read_data | i_register_read_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_status    = w_status | i_register_status[2*k +: 2];
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) w_mask[i] = i_host_strobe[i/8];
    end

`ifdef RGGEN_REGISTER_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] r_count;
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state != ACCESS) r_count <= '0;
        else                            r_count <= r_count + 1'b1;
    end
    assign w_timeout = r_count == CW'(TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_host_valid) w_next = ACCESS;
            ACCESS:   if (!w_hit || w_done || w_timeout) w_next = RESPONSE;
            RESPONSE: if (i_host_response_ready) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_address    <= '0;
            r_write      <= 1'b0;
            r_write_data <= '0;
            r_strobe     <= '0;
            r_mask       <= '0;
            r_read_data  <= '0;
            r_status     <= '0;
        end else begin
            if (r_state == IDLE && i_host_valid) begin
                r_address    <= i_host_address;
                r_write      <= i_host_write;
                r_write_data <= i_host_write_data;
                r_strobe     <= i_host_strobe;
                r_mask       <= w_mask;
            end
            if (r_state == ACCESS && w_next == RESPONSE) begin
                r_read_data <= (w_hit && w_done && !r_write) ? w_read_data : '0;
                r_status    <= !w_hit ? 2'd3 : w_done ? w_status : 2'd2;
            end
        end
    end

    assign o_host_ready            = r_state == IDLE;
    assign o_host_response_valid   = r_state == RESPONSE;
    assign o_register_request      = r_state == ACCESS;
    assign o_host_read_data        = r_read_data;
    assign o_host_status           = r_status;
    assign o_register_address      = r_address;
    assign o_register_direction    = r_write;
    assign o_register_write_data   = r_write_data;
    assign o_register_write_strobe = r_strobe;
    assign o_register_write_mask   = r_mask;
endmodule

// File: tb/tb_rggen_register_master.sv
// tb_rggen_register_master: directed scoreboard bench for the register master with two slaves.
module tb_rggen_register_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int N  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_valid;
    logic          host_ready;
    logic [AW-1:0] host_address;
    logic          host_write;
    logic [DW-1:0] host_write_data;
    logic [3:0]    host_strobe;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] read_data;
    logic [1:0]    status;
    logic          req;
    logic [AW-1:0] reg_address;
    logic          reg_direction;
    logic [DW-1:0] reg_write_data;
    logic [3:0]    reg_strobe;
    logic [DW-1:0] reg_mask;
    logic [N-1:0]  reg_select;
    logic [N-1:0]  reg_ready;
    logic [N*DW-1:0] reg_read_data;
    logic [2*N-1:0]  reg_status;

    typedef struct {logic [31:0] d; logic [1:0] s;} exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rggen_register_master #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTERS(N), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_host_valid(host_valid), .o_host_ready(host_ready),
        .i_host_address(host_address), .i_host_write(host_write),
        .i_host_write_data(host_write_data), .i_host_strobe(host_strobe),
        .o_host_response_valid(resp_valid), .i_host_response_ready(resp_ready),
        .o_host_read_data(read_data), .o_host_status(status),
        .o_register_request(req), .o_register_address(reg_address),
        .o_register_direction(reg_direction), .o_register_write_data(reg_write_data),
        .o_register_write_strobe(reg_strobe), .o_register_write_mask(reg_mask),
        .i_register_select(reg_select), .i_register_ready(reg_ready),
        .i_register_read_data(reg_read_data), .i_register_status(reg_status)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_response();
        exp_t e;
        chk("resp_valid", resp_valid, 1);
        if (resp_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("resp_data", read_data, e.d);
            chk("resp_status", status, e.s);
        end
    endtask

    task automatic start(input logic [15:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] st);
        host_valid = 1; host_address = a; host_write = wr; host_write_data = wd; host_strobe = st;
        cyc();
        host_valid = 0;
        chk("req_rise", req, 1);
        chk("host_ready_busy", host_ready, 0);
        chk("reg_address", reg_address, a);
        chk("reg_direction", reg_direction, wr);
        chk("reg_write_data", reg_write_data, wr ? wd : wd);
        chk("reg_strobe", reg_strobe, st);
        chk("reg_mask", reg_mask, {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}});
    endtask

    task automatic access(input logic [15:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] st,
                          input logic [1:0] sel, input int waits, input logic [63:0] rd, input logic [3:0] rs,
                          input logic [31:0] ed, input logic [1:0] es, input int hold);
        exp_t e;
        int n;
        resp_ready = (hold == 0);
        start(a, wr, wd, st);
        e.d = ed; e.s = es;
        q.push_back(e);
        reg_read_data = rd; reg_status = rs; reg_select = sel; reg_ready = '0;
        n = 0;
        for (int i = 0; i < waits; i++) begin
            if (req) n++;
            cyc();
        end
        reg_ready = sel;
        for (int i = 0; i < 100 && !resp_valid; i++) begin
            if (req) n++;
            cyc();
        end
        reg_select = '0; reg_ready = '0;
        chk("req_cycles", n, waits + 1);
        chk("req_drop", req, 0);
        check_response();
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", read_data, ed);
            chk("hold_status", status, es);
            chk("hold_host_ready", host_ready, 0);
            chk("hold_req", req, 0);
        end
        resp_ready = 1;
        cyc();
        chk("idle_host_ready", host_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);
    endtask

    initial begin
        exp_t e;
        int n;
        rst = 1; host_valid = 0; host_address = '0; host_write = 0; host_write_data = '0; host_strobe = '0;
        resp_ready = 1; reg_select = '0; reg_ready = '0; reg_read_data = '0; reg_status = '0;
        cyc(); cyc();
        rst = 0;
        chk("rst_host_ready", host_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req", req, 0);
        chk("rst_mask", reg_mask, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_status", status, 0);
        cyc();
        // write, slave0 ready immediately; writes return zero data
        access(16'h0010, 1, 32'hA5A5_1234, 4'b0011, 2'b01, 0, {32'h0, 32'h1111_2222}, 4'b0000, 32'h0, 2'd0, 0);
        // read with three wait cycles from slave1
        access(16'h0014, 0, 32'h0, 4'b1111, 2'b10, 3, {32'hDEAD_BEEF, 32'h0}, 4'b0000, 32'hDEAD_BEEF, 2'd0, 0);
        // unmapped read gives decode error, response held while host stalls
        access(16'h0FFC, 0, 32'h0, 4'b0000, 2'b00, 0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b1111, 32'h0, 2'd3, 5);
        // both slaves answer: OR-merged data and status
        access(16'h0018, 0, 32'h0, 4'b1100, 2'b11, 1, {32'h0000_00F0, 32'h0000_000F}, 4'b0001, 32'h0000_00FF, 2'd1, 0);
        // selected slave never becomes ready
        start(16'h0030, 0, 32'h0, 4'b0101);
        reg_select = 2'b01; reg_ready = 2'b00; reg_read_data = {32'h0, 32'h1234_5678}; reg_status = 4'b0000;
        n = 0;
        for (int i = 0; i < 40 && !resp_valid; i++) begin
            if (req) n++;
            cyc();
        end
`ifdef RGGEN_REGISTER_MASTER_TIMEOUT_EN
        e.d = 32'h0; e.s = 2'd2;
        q.push_back(e);
        chk("timeout_cycles", n, 8);
`else
        chk("no_timeout_cycles", n, 40);
        chk("no_timeout_req", req, 1);
        chk("no_timeout_valid", resp_valid, 0);
        e.d = 32'h1234_5678; e.s = 2'd0;
        q.push_back(e);
        reg_ready = 2'b01;
        cyc();
`endif
        reg_select = '0; reg_ready = '0;
        check_response();
        cyc();
        chk("after_slow_ready", host_ready, 1);
        // reset in the middle of an access discards it
        start(16'h0020, 1, 32'hCAFE_F00D, 4'b1111);
        reg_select = 2'b10; reg_ready = 2'b00;
        cyc();
        chk("mid_req", req, 1);
        rst = 1;
        cyc();
        rst = 0; reg_select = '0;
        q.delete();
        chk("mrst_req", req, 0);
        chk("mrst_host_ready", host_ready, 1);
        chk("mrst_resp_valid", resp_valid, 0);
        chk("mrst_address", reg_address, 0);
        chk("mrst_direction", reg_direction, 0);
        chk("mrst_write_data", reg_write_data, 0);
        chk("mrst_strobe", reg_strobe, 0);
        chk("mrst_mask", reg_mask, 0);
        chk("mrst_read_data", read_data, 0);
        chk("mrst_status", status, 0);
        cyc();
        chk("mrst_stay_idle", req, 0);
        // normal operation resumes after reset
        access(16'h0024, 0, 32'h0, 4'b1000, 2'b01, 2, {32'h0, 32'h0BAD_CAFE}, 4'b0001, 32'h0BAD_CAFE, 2'd1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
